// File: rtl/uart_echo_fifo.sv
// UART echo engine: 16x-oversampled receiver feeding a small FIFO that drains into
// a matching transmitter. Errored frames are dropped and reported as status pulses.
module uart_echo_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          RsRx,
  output logic                          RsTx,
  input  logic                          tx_pause,
  output logic                          tx_busy,
  output logic                          rx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overflow
);
  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    par_bit = (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  logic [DIV_W-1:0]     div_q, div_d;
  logic                 tick;
  logic                 rx_s1_q, rx_s2_q, rx_sync;
  rx_state_t            rx_state_q, rx_state_d;
  logic [OS_W-1:0]      rx_tcnt_q, rx_tcnt_d;
  logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 frame_err_q, frame_err_d, parity_err_q, parity_err_d;
  logic                 rx_push;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 fifo_full, fifo_pop, do_push;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] rd_data_q;
  tx_state_t            tx_state_q, tx_state_d;
  logic                 tx_armed_q, tx_armed_d;
  logic [OS_W-1:0]      tx_tcnt_q, tx_tcnt_d;
  logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_q, tx_d;

  assign rx_sync = rx_s2_q;

  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + 1'b1;
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_tcnt_d    = rx_tcnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_perr_d    = rx_perr_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    rx_push      = 1'b0;
    if (tick) begin
      case (rx_state_q)
        RX_IDLE: if (!rx_sync) begin
          rx_state_d = RX_START;
          rx_tcnt_d  = '0;
        end
        RX_START: if (rx_tcnt_q == OS_HALF) begin
          // A line that is high again at mid start bit was only a glitch.
          rx_tcnt_d  = '0;
          rx_bit_d   = '0;
          rx_perr_d  = 1'b0;
          rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
        end else rx_tcnt_d = rx_tcnt_q + 1'b1;
        RX_DATA: if (rx_tcnt_q == OS_LAST) begin
          rx_tcnt_d  = '0;
          rx_shift_d = {rx_sync, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == BIT_LAST) rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
          else rx_bit_d = rx_bit_q + 1'b1;
        end else rx_tcnt_d = rx_tcnt_q + 1'b1;
        RX_PARITY: if (rx_tcnt_q == OS_LAST) begin
          rx_tcnt_d  = '0;
          rx_perr_d  = (rx_sync != par_bit(rx_shift_q));
          rx_state_d = RX_STOP;
        end else rx_tcnt_d = rx_tcnt_q + 1'b1;
        RX_STOP: if (rx_tcnt_q == OS_LAST) begin
          rx_tcnt_d  = '0;
          rx_state_d = RX_IDLE;
          if (!rx_sync)       frame_err_d  = 1'b1;
          else if (rx_perr_q) parity_err_d = 1'b1;
          else                rx_push      = 1'b1;
        end else rx_tcnt_d = rx_tcnt_q + 1'b1;
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    fifo_full  = (count_q == CNT_FULL);
    do_push    = rx_push && (!fifo_full || fifo_pop);
    overflow_d = overflow_q | (rx_push && fifo_full && !fifo_pop);
    wr_ptr_d   = do_push  ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = fifo_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({do_push, fifo_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_armed_d = tx_armed_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    fifo_pop   = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        // Pop first; the registered read data is valid by the following tick.
        if (!tx_armed_q) begin
          if ((count_q != '0) && !tx_pause) begin
            fifo_pop   = 1'b1;
            tx_armed_d = 1'b1;
          end
        end else if (tick) begin
          tx_armed_d = 1'b0;
          tx_shift_d = rd_data_q;
          tx_tcnt_d  = '0;
          tx_state_d = TX_START;
          tx_d       = 1'b0;
        end
      end
      TX_START: if (tick) begin
        if (tx_tcnt_q == OS_LAST) begin
          tx_tcnt_d  = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
          tx_d       = tx_shift_q[0];
        end else tx_tcnt_d = tx_tcnt_q + 1'b1;
      end
      TX_DATA: if (tick) begin
        if (tx_tcnt_q == OS_LAST) begin
          tx_tcnt_d = '0;
          if (tx_bit_q == BIT_LAST) begin
            tx_state_d = (PARITY != 0) ? TX_PARITY : TX_STOP;
            tx_d       = (PARITY != 0) ? par_bit(tx_shift_q) : 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
            tx_d     = tx_shift_q[tx_bit_d];
          end
        end else tx_tcnt_d = tx_tcnt_q + 1'b1;
      end
      TX_PARITY: if (tick) begin
        if (tx_tcnt_q == OS_LAST) begin
          tx_tcnt_d  = '0;
          tx_state_d = TX_STOP;
          tx_d       = 1'b1;
        end else tx_tcnt_d = tx_tcnt_q + 1'b1;
      end
      TX_STOP: if (tick) begin
        if (tx_tcnt_q == OS_LAST) begin
          tx_tcnt_d  = '0;
          tx_state_d = TX_IDLE;
        end else tx_tcnt_d = tx_tcnt_q + 1'b1;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q        <= '0;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_tcnt_q    <= '0;
      rx_bit_q     <= '0;
      rx_perr_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      tx_state_q   <= TX_IDLE;
      tx_armed_q   <= 1'b0;
      tx_tcnt_q    <= '0;
      tx_bit_q     <= '0;
      tx_q         <= 1'b1;
    end else begin
      div_q        <= div_d;
      rx_s1_q      <= RsRx;
      rx_s2_q      <= rx_s1_q;
      rx_state_q   <= rx_state_d;
      rx_tcnt_q    <= rx_tcnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_perr_q    <= rx_perr_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      tx_state_q   <= tx_state_d;
      tx_armed_q   <= tx_armed_d;
      tx_tcnt_q    <= tx_tcnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_q         <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    rx_shift_q <= rx_shift_d;
    tx_shift_q <= tx_shift_d;
    if (do_push)  mem_q[wr_ptr_q] <= rx_shift_q;
    if (fifo_pop) rd_data_q <= mem_q[rd_ptr_q];
  end

  assign RsTx       = tx_q;
  assign tx_busy    = (tx_state_q != TX_IDLE);
  assign rx_busy    = (rx_state_q != RX_IDLE);
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_uart_echo_fifo.sv
// Bench for uart_echo_fifo: two instances (no parity / even parity) driven with
// serial frames; a line-level monitor decodes RsTx and results are held against a queue model.
module tb_uart_echo_fifo;
  localparam int CPB = 160;

  logic       clk;
  logic [1:0] rst_v, rx_v, pause_v;
  logic       tx0, tx1, txb0, txb1, rxb0, rxb1, fe0, fe1, pe0, pe1, ov0, ov1;
  logic [2:0] cnt0, cnt1;

  int n_checks = 0;
  int n_pass   = 0;
  int fe_n0 = 0, fe_n1 = 0, pe_n0 = 0, pe_n1 = 0;
  time stop_t [2];
  time fall_t [2];
  logic [7:0] cap0 [$];
  logic [7:0] cap1 [$];

  uart_echo_fifo #(.CLK_FREQ(1600000), .BAUD(10000), .OVERSAMPLE(16), .DATA_BITS(8),
                   .PARITY(0), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst(rst_v[0]), .RsRx(rx_v[0]), .RsTx(tx0), .tx_pause(pause_v[0]),
    .tx_busy(txb0), .rx_busy(rxb0), .fifo_count(cnt0), .frame_err(fe0),
    .parity_err(pe0), .overflow(ov0));

  uart_echo_fifo #(.CLK_FREQ(1600000), .BAUD(10000), .OVERSAMPLE(16), .DATA_BITS(8),
                   .PARITY(2), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst_v[1]), .RsRx(rx_v[1]), .RsTx(tx1), .tx_pause(pause_v[1]),
    .tx_busy(txb1), .rx_busy(rxb1), .fifo_count(cnt1), .frame_err(fe1),
    .parity_err(pe1), .overflow(ov1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fe0 === 1'b1) fe_n0++;
    if (fe1 === 1'b1) fe_n1++;
    if (pe0 === 1'b1) pe_n0++;
    if (pe1 === 1'b1) pe_n1++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input int sel, input logic [7:0] d, input bit with_par,
                           input bit pbit, input bit sbit);
    @(negedge clk);
    rx_v[sel] = 1'b0;
    wait_clk(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_v[sel] = d[i];
      wait_clk(CPB);
    end
    if (with_par) begin
      rx_v[sel] = pbit;
      wait_clk(CPB);
    end
    stop_t[sel] = $time;
    rx_v[sel] = sbit;
    wait_clk(CPB);
    rx_v[sel] = 1'b1;
  endtask

  // Decodes one frame per falling edge on RsTx, sampling at mid-bit; frames cut by rst are dropped.
  task automatic mon(input int sel);
    logic [7:0] d;
    logic p, s;
    bit ab;
    forever begin
      @(negedge clk);
      if (((sel == 0) ? tx0 : tx1) === 1'b0) begin
        fall_t[sel] = $time;
        ab = 0; d = '0; p = 1'b0;
        for (int k = 0; k < CPB / 2; k++) begin
          @(negedge clk);
          if (rst_v[sel]) ab = 1;
        end
        for (int b = 0; b < ((sel == 0) ? 9 : 10); b++) begin
          for (int k = 0; k < CPB; k++) begin
            @(negedge clk);
            if (rst_v[sel]) ab = 1;
          end
          if (b < 8) d[b] = (sel == 0) ? tx0 : tx1;
          else if (sel == 1 && b == 8) p = tx1;
          else s = (sel == 0) ? tx0 : tx1;
        end
        if (!ab) begin
          check_val($sformatf("stop_bit%0d", sel), {31'b0, s}, 32'd1);
          if (sel == 1) begin
            check_val("tx_parity", {31'b0, p}, $countones(d) % 2);
            cap1.push_back(d);
          end else cap0.push_back(d);
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  initial begin
    int fe_s, pe_s, lat, nbad, n0, found;
    logic [7:0] d, q;
    logic [7:0] exp0 [$];
    logic [7:0] exp1 [$];
    rx_v = 2'b11; pause_v = 2'b00; rst_v = 2'b11;
    wait_clk(3);
    check_val("rst_tx0", {31'b0, tx0}, 1);
    check_val("rst_tx1", {31'b0, tx1}, 1);
    check_val("rst_txbusy", {30'b0, txb1, txb0}, 0);
    check_val("rst_rxbusy", {30'b0, rxb1, rxb0}, 0);
    check_val("rst_count", {26'b0, cnt1, cnt0}, 0);
    check_val("rst_errs", {28'b0, fe1, fe0, pe1, pe0}, 0);
    check_val("rst_ovf", {30'b0, ov1, ov0}, 0);
    rst_v = 2'b00;
    wait_clk(20);

    // Plain echo with latency
    fe_s = fe_n0; pe_s = pe_n0;
    send_byte(0, 8'h55, 0, 0, 1);
    wait_clk(2000);
    check_val("echo55_n", cap0.size(), 1);
    check_val("echo55_d", (cap0.size() > 0) ? cap0[0] : 32'hdead, 8'h55);
    lat = int'((fall_t[0] - stop_t[0]) / 10);
    check_val("latency_in_80_120", (lat >= 80 && lat <= 120) ? 1 : 0, 1);
    check_val("echo55_cnt", cnt0, 0);
    check_val("echo55_errs", (fe_n0 - fe_s) + (pe_n0 - pe_s), 0);
    cap0.delete();

    // Even parity: good then bad parity bit
    send_byte(1, 8'hA3, 1, 0, 1);
    wait_clk(2200);
    check_val("parA3_n", cap1.size(), 1);
    check_val("parA3_d", (cap1.size() > 0) ? cap1[0] : 32'hdead, 8'hA3);
    pe_s = pe_n1;
    send_byte(1, 8'hA3, 1, 1, 1);
    wait_clk(500);
    check_val("parerr_pulse", pe_n1 - pe_s, 1);
    check_val("parerr_noecho", cap1.size(), 1);
    check_val("parerr_cnt", cnt1, 0);
    cap1.delete();

    // Frame error
    fe_s = fe_n0; pe_s = pe_n0;
    send_byte(0, 8'h3C, 0, 0, 0);
    wait_clk(400);
    check_val("frerr_pulse", fe_n0 - fe_s, 1);
    check_val("frerr_pe", pe_n0 - pe_s, 0);
    check_val("frerr_tx", tx0, 1);
    check_val("frerr_cnt", cnt0, 0);
    wait_clk(1800);
    check_val("frerr_noecho", cap0.size(), 0);

    // Short glitch on RsRx
    fe_s = fe_n0; pe_s = pe_n0;
    @(negedge clk);
    rx_v[0] = 1'b0;
    wait_clk(40);
    check_val("glitch_busy", rxb0, 1);
    wait_clk(10);
    rx_v[0] = 1'b1;
    wait_clk(200);
    check_val("glitch_idle", rxb0, 0);
    check_val("glitch_errs", (fe_n0 - fe_s) + (pe_n0 - pe_s), 0);
    check_val("glitch_cnt", cnt0, 0);
    wait_clk(1800);
    check_val("glitch_noecho", cap0.size(), 0);

    // Randomised traffic against the queue model
    fe_s = fe_n0;
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      exp0.push_back(d);
      send_byte(0, d, 0, 0, 1);
      wait_clk($urandom_range(0, 100));
    end
    pe_s = pe_n1; nbad = 0;
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) begin
        nbad++;
        send_byte(1, d, 1, ~($countones(d) % 2 == 1), 1);
      end else begin
        exp1.push_back(d);
        send_byte(1, d, 1, ($countones(d) % 2 == 1), 1);
      end
      wait_clk($urandom_range(0, 100));
    end
    wait_clk(2500);
    check_val("rnd0_n", cap0.size(), exp0.size());
    for (int i = 0; i < exp0.size(); i++)
      check_val($sformatf("rnd0_d%0d", i), (i < cap0.size()) ? cap0[i] : 32'hdead, exp0[i]);
    check_val("rnd1_n", cap1.size(), exp1.size());
    for (int i = 0; i < exp1.size(); i++)
      check_val($sformatf("rnd1_d%0d", i), (i < cap1.size()) ? cap1[i] : 32'hdead, exp1[i]);
    check_val("rnd1_perr", pe_n1 - pe_s, nbad);
    check_val("rnd0_ferr", fe_n0 - fe_s, 0);
    check_val("rnd_ovf", {30'b0, ov1, ov0}, 0);
    cap0.delete(); cap1.delete(); exp0.delete();

    // Paused TX fills the FIFO and overflows
    pause_v[0] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      send_byte(0, 8'(i), 0, 0, 1);
      if (i <= 4) exp0.push_back(8'(i));
      check_val($sformatf("pause_cnt%0d", i), cnt0, (i < 4) ? i : 4);
      check_val($sformatf("pause_ovf%0d", i), ov0, (i >= 5) ? 1 : 0);
    end
    pause_v[0] = 1'b0;
    wait_clk(4 * 1800 + 300);
    check_val("drain_n", cap0.size(), exp0.size());
    for (int i = 0; i < exp0.size(); i++)
      check_val($sformatf("drain_d%0d", i), (i < cap0.size()) ? cap0[i] : 32'hdead, exp0[i]);
    check_val("drain_cnt", cnt0, 0);
    check_val("drain_ovf_sticky", ov0, 1);
    cap0.delete();

    // Asynchronous reset in the middle of a frame
    pause_v[0] = 1'b1;
    send_byte(0, 8'hF0, 0, 0, 1);
    send_byte(0, 8'hA5, 0, 0, 1);
    send_byte(0, 8'h3C, 0, 0, 1);
    check_val("rstq_cnt", cnt0, 3);
    pause_v[0] = 1'b0;
    found = 0;
    for (int k = 0; k < 100 && found == 0; k++) begin
      wait_clk(1);
      if (tx0 === 1'b0) found = 1;
    end
    check_val("rstq_txstart", found, 1);
    wait_clk(5 * CPB);
    check_val("rstq_busy", txb0, 1);
    check_val("rstq_cnt2", cnt0, 2);
    #2 rst_v[0] = 1'b1;
    #1;
    check_val("arst_tx", tx0, 1);
    check_val("arst_cnt", cnt0, 0);
    check_val("arst_busy", txb0, 0);
    check_val("arst_ovf", ov0, 0);
    wait_clk(3);
    rst_v[0] = 1'b0;
    n0 = cap0.size();
    wait_clk(4000);
    check_val("arst_noecho", cap0.size(), n0);
    check_val("arst_tx_idle", tx0, 1);
    check_val("arst_cnt_end", cnt0, 0);
    q = 8'h00;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_echo_fifo.md
Name: uart_echo_fifo

Overview:
- Parametrised, self-contained UART loopback/echo engine for the Basys3 serial link.
- Contains a 16x-oversampled receiver with configurable data width and parity, a synchronous FIFO, and a matching transmitter.
- Every correctly framed byte received on RsRx is queued and retransmitted on RsTx. Unlike the single-shot echo path, bytes arriving while the transmitter is busy are buffered rather than lost.
- Frame, parity and overflow errors are reported as status outputs.

Parameters:
- CLK_FREQ, 100000000: system clock frequency in Hz.
- BAUD, 9600: line rate in bits/s.
- OVERSAMPLE, 16: sample ticks per bit period; even, at least 8.
- DATA_BITS, 8: payload bits per frame, 5 to 8.
- PARITY, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- FIFO_DEPTH, 16: FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- RsRx  in  1  serial input; asynchronous, idle high.
- RsTx  out  1  serial output; idle high.
- tx_pause  in  1  when high, TX does not start a new frame; a frame already in progress completes.
- tx_busy  out  1  high while TX is in any state other than IDLE.
- rx_busy  out  1  high while RX is in any state other than IDLE.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current number of FIFO entries.
- frame_err  out  1  one-clk pulse when a stop bit is sampled low.
- parity_err  out  1  one-clk pulse on a parity mismatch.
- overflow  out  1  sticky; set when a valid byte arrives with the FIFO full; cleared only by rst.

Behaviour:
- Reset values:
  - RsTx=1; tx_busy=0; rx_busy=0; fifo_count=0; frame_err=0; parity_err=0; overflow=0.
  - FIFO pointers 0; both FSMs in IDLE; synchroniser flops 1.
- Reset is asynchronous: asserting rst mid-frame forces RsTx high immediately, discards the in-flight RX frame, and empties the FIFO.
- Tick generator:
  - Divider DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer-truncated.
  - Counts 0..DIV-1 and emits a one-clk tick at DIV-1.
  - Free-running; shared by RX and TX.
- RX synchronisation: RsRx passes through a 2-flop synchroniser. All RX decisions use the synchronised value.
- RX FSM (advances only on ticks):
  - IDLE -> START on a synchronised low.
  - START: at tick OVERSAMPLE/2-1, the line is sampled.
    - If high, the low is treated as a glitch: return to IDLE, no error.
    - If low, reset the tick counter and go to DATA.
  - DATA: sample at mid-bit, i.e. every OVERSAMPLE ticks. Shift DATA_BITS bits, LSB first.
  - PARITY (only when PARITY≠0): sample the parity bit. Odd mode requires the XOR of data and parity bits to be 1; even mode requires 0. A mismatch sets an internal flag.
  - STOP: sample at mid-bit.
    - Stop bit 0: pulse frame_err, drop the byte.
    - Stop bit 1 with the parity flag set: pulse parity_err, drop the byte.
    - Otherwise: push the byte into the FIFO.
    - In all cases return to IDLE in the same clk. The next start bit can be detected on the following tick.
- FIFO:
  - Width DATA_BITS, depth FIFO_DEPTH; pointers wrap modulo depth.
  - Push when full: the byte is discarded and overflow is set, unless a pop occurs in the same clk. In that case both the push and the pop occur, count is unchanged, and overflow is not set.
  - Push and pop in the same clk when not full: both occur, count unchanged.
  - Pop is never issued while empty.
  - Read data is registered. A pop in cycle N presents the byte to TX in cycle N+1.
- TX FSM (bit period = OVERSAMPLE ticks):
  - IDLE: when fifo_count≠0 and tx_pause=0, pop the FIFO, latch the byte, and go to START on the next tick.
  - START drives 0.
  - DATA drives DATA_BITS bits, LSB first.
  - PARITY (only when enabled) drives the computed parity bit.
  - STOP drives 1 for one bit period, then returns to IDLE.
  - Back-to-back frames are allowed with no idle gap beyond one tick.
  - RsTx is registered, so it is glitch-free.
- Latency: RsTx falls within 2 ticks + 4 clk of the RX stop-bit mid-sample, provided TX is idle, tx_pause=0 and the FIFO was empty.

Test Plan:
Common bench setup: CLK_FREQ=1600000, BAUD=10000, OVERSAMPLE=16 (DIV=10, 160 clk/bit), FIFO_DEPTH=4.
- Defaults otherwise: send 0x55 -> RsTx carries frame 0,1,0,1,0,1,0,1,0,1; fifo_count returns to 0; no error pulses; latency bound met.
- PARITY=2: send 0xA3 with correct parity bit 0 -> echoed with parity 0. Then send 0xA3 with parity bit 1 -> one parity_err pulse, no echo, fifo_count stays 0.
- Send 0x3C with stop bit 0 -> one frame_err pulse, RsTx stays high, fifo_count 0.
- Hold tx_pause=1 and send 0x01..0x06 back-to-back:
  - fifo_count reaches 4; overflow sets on byte 0x05 and stays set.
  - Release tx_pause -> RsTx emits 0x01, 0x02, 0x03, 0x04 in order; fifo_count ends at 0.
- Drive RsRx low for 50 clk, then high -> no rx frame, rx_busy returns to 0, no error pulses.
- Assert rst midway through transmitting 0xF0 with 2 bytes queued -> RsTx=1 in the same cycle, fifo_count=0, tx_busy=0, and nothing further is transmitted.
